// File: rtl/l2c_miss_ctrl_nch_pkg.sv
// Shared types for the L2 miss/replacement controller: per-channel state encoding
// and the default channel count.
package RVS192_package;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ACK  = 3'd1,
    ST_ARB       = 3'd2,
    ST_M_DIRTY   = 3'd3,
    ST_WB_WAIT   = 3'd4,
    ST_M_REPLACE = 3'd5
  } l2c_ch_state_e;

  localparam int L2C_DEFAULT_NUM_CH = 2;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/l2c_miss_ctrl_nch_if.sv
// L1-side handshake and shared memory-port bundle of the miss controller.
// master = controller, slave = L1 synchronisers / memory / write buffer.
interface l2c_miss_ctrl_nch_if #(
  parameter int NUM_CH  = 2,
  parameter int ACK_SRC = 2
);
  import RVS192_package::*;
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]         l1_replace_req;
  logic [NUM_CH-1:0]         miss;
  logic [NUM_CH-1:0]         dirty;
  logic [NUM_CH-1:0]         wb_read_tag_hit;
  logic [NUM_CH*ACK_SRC-1:0] replace_ack_sync;
  logic [NUM_CH-1:0]         replace_req;
  logic [NUM_CH-1:0]         update_ena;
  logic                      mem_dirty_req;
  logic                      mem_replace_req;
  logic                      mem_addr_sel;
  logic [CH_W-1:0]           mem_ch_id;
  logic                      mem_dirty_done;
  logic                      mem_replace_done;
  logic [NUM_CH-1:0]         ack_timeout_err;

  modport master (
    input  l1_replace_req, miss, dirty, wb_read_tag_hit, replace_ack_sync,
           mem_dirty_done, mem_replace_done,
    output replace_req, update_ena, mem_dirty_req, mem_replace_req,
           mem_addr_sel, mem_ch_id, ack_timeout_err
  );

  modport slave (
    output l1_replace_req, miss, dirty, wb_read_tag_hit, replace_ack_sync,
           mem_dirty_done, mem_replace_done,
    input  replace_req, update_ena, mem_dirty_req, mem_replace_req,
           mem_addr_sel, mem_ch_id, ack_timeout_err
  );
endinterface

// File: rtl/l2c_miss_ctrl_nch_arb.sv
// Round-robin arbiter for the shared memory port. Grants only while the port is
// free; on release the search pointer moves to one past the last granted channel.
module l2c_rr_arbiter
  import RVS192_package::*;
#(
  parameter int NUM_CH = 2,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              busy,
  input  logic              rel,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_id
);
  logic [CH_W-1:0] ptr, last;
  logic            found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && !busy && req[(int'(ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        gnt[(int'(ptr) + k) % NUM_CH] = 1'b1;
        gnt_id = CH_W'((int'(ptr) + k) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr  <= '0;
      last <= '0;
    end else begin
      if (|gnt) last <= gnt_id;
      if (rel)  ptr  <= (last == CH_W'(NUM_CH - 1)) ? '0 : last + 1'b1;
    end
  end
endmodule

// File: rtl/l2c_miss_ctrl_nch.sv
// NUM_CH-channel L2 miss/replacement controller sharing one memory port.
// Optional L1 ack timeout enabled by defining L2C_ACK_TIMEOUT_EN.
module l2c_miss_ctrl_nch
  import RVS192_package::*;
#(
  parameter int NUM_CH  = L2C_DEFAULT_NUM_CH,
  parameter int ACK_SRC = 2,
  parameter int TO_W    = 8
) (
  input logic                 clk_l2,
  input logic                 rst_n,
  l2c_miss_ctrl_nch_if.master bus
);
  localparam int CH_W = ch_w(NUM_CH);

  logic              owner_vld, owner_vld_n;
  logic [CH_W-1:0]   owner, owner_n, gnt_id;
  logic [NUM_CH-1:0] arb_req, gnt, rel_v, rreq_n, upd_n, to_hit, err_v;
  logic [NUM_CH-1:0] nxt_dirty, nxt_repl;
  logic              dreq_n, rpl_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    l2c_ch_state_e      st, st_n;
    logic [ACK_SRC-1:0] ack;
    logic               is_own;

    assign ack          = bus.replace_ack_sync[i*ACK_SRC +: ACK_SRC];
    assign is_own       = owner_vld && (owner == CH_W'(i));
    assign arb_req[i]   = (st == ST_ARB);
    assign nxt_dirty[i] = (st_n == ST_M_DIRTY);
    assign nxt_repl[i]  = (st_n == ST_M_REPLACE);

    always_comb begin
      st_n      = st;
      rreq_n[i] = 1'b0;
      upd_n[i]  = 1'b0;
      rel_v[i]  = 1'b0;
      case (st)
        ST_IDLE:
          if (bus.l1_replace_req[i]) begin
            if (bus.miss[i]) begin
              st_n      = ST_WAIT_ACK;
              rreq_n[i] = 1'b1;
            end else begin
              upd_n[i]  = 1'b1;
            end
          end
        ST_WAIT_ACK:
          if ((|ack) || to_hit[i]) st_n = ST_ARB;
        ST_ARB:
          if (gnt[i])
            st_n = bus.dirty[i]           ? ST_M_DIRTY :
                   bus.wb_read_tag_hit[i] ? ST_WB_WAIT : ST_M_REPLACE;
        ST_M_DIRTY:
          if (is_own && bus.mem_dirty_done)
            st_n = bus.wb_read_tag_hit[i] ? ST_WB_WAIT : ST_M_REPLACE;
        ST_WB_WAIT:
          if (!bus.wb_read_tag_hit[i]) st_n = ST_M_REPLACE;
        ST_M_REPLACE:
          if (is_own && bus.mem_replace_done) begin
            st_n      = ST_IDLE;
            upd_n[i]  = 1'b1;
            rel_v[i]  = 1'b1;
          end
        default: st_n = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk_l2) begin
      if (!rst_n) st <= ST_IDLE;
      else        st <= st_n;
    end

`ifdef L2C_ACK_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_err;

    // Expires on the all-ones cycle only if no ack arrived in that same cycle.
    assign to_hit[i] = (st == ST_WAIT_ACK) && (&to_cnt) && !(|ack);
    assign err_v[i]  = to_err;

    always_ff @(posedge clk_l2) begin
      if (!rst_n) begin
        to_cnt <= '0;
        to_err <= 1'b0;
      end else begin
        if (st != ST_WAIT_ACK)  to_cnt <= '0;
        else                    to_cnt <= to_cnt + 1'b1;
        if (to_hit[i])          to_err <= 1'b1;
      end
    end
`else
    assign to_hit[i] = 1'b0;
    assign err_v[i]  = 1'b0;
`endif
  end

  l2c_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk    (clk_l2),
    .rst_n  (rst_n),
    .req    (arb_req),
    .busy   (owner_vld),
    .rel    (|rel_v),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Grant and release are mutually exclusive: grants need a free port.
  always_comb begin
    owner_vld_n = owner_vld;
    owner_n     = owner;
    if (|rel_v) begin
      owner_vld_n = 1'b0;
      owner_n     = '0;
    end else if (|gnt) begin
      owner_vld_n = 1'b1;
      owner_n     = gnt_id;
    end
    dreq_n = owner_vld_n && nxt_dirty[owner_n];
    rpl_n  = owner_vld_n && nxt_repl[owner_n];
  end

  always_ff @(posedge clk_l2) begin
    if (!rst_n) begin
      owner_vld           <= 1'b0;
      owner               <= '0;
      bus.replace_req     <= '0;
      bus.update_ena      <= '0;
      bus.mem_dirty_req   <= 1'b0;
      bus.mem_replace_req <= 1'b0;
      bus.mem_addr_sel    <= 1'b0;
      bus.mem_ch_id       <= '0;
    end else begin
      owner_vld           <= owner_vld_n;
      owner               <= owner_n;
      bus.replace_req     <= rreq_n;
      bus.update_ena      <= upd_n;
      bus.mem_dirty_req   <= dreq_n;
      bus.mem_replace_req <= rpl_n;
      bus.mem_addr_sel    <= dreq_n;
      bus.mem_ch_id       <= (dreq_n || rpl_n) ? owner_n : '0;
    end
  end

  assign bus.ack_timeout_err = err_v;
endmodule

// File: tb/tb_l2c_miss_ctrl_nch.sv
// Bench for l2c_miss_ctrl_nch: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the channels.
module tb_l2c_miss_ctrl_nch;
  localparam int NCH  = 4;
  localparam int NACK = 2;
  localparam int TOW  = 4;
  localparam int TO_LIMIT = (1 << TOW) - 1;

  // model phases of a channel's miss handling
  localparam int P_IDLE = 0, P_ACK = 1, P_QUEUE = 2, P_WBACK = 3, P_STALL = 4, P_FILL = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2c_miss_ctrl_nch_if #(.NUM_CH(NCH), .ACK_SRC(NACK)) bus ();

  l2c_miss_ctrl_nch #(.NUM_CH(NCH), .ACK_SRC(NACK), .TO_W(TOW)) dut (
    .clk_l2 (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_vec = 0, n_err = 0;

  int ph [NCH];
  int tcnt [NCH];
  bit terr [NCH];
  int own = -1, rr = 0;
  bit [NCH-1:0] e_rreq, e_upd, e_err;
  bit e_dreq, e_rpl;
  int e_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    logic [NACK-1:0] a;
    e_rreq = '0;
    e_upd  = '0;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin ph[c] = P_IDLE; tcnt[c] = 0; terr[c] = 0; end
      own = -1; rr = 0;
    end else begin
      g = -1;
      if (own < 0)
        for (int k = 0; k < NCH; k++)
          if (g < 0 && ph[(rr + k) % NCH] == P_QUEUE) g = (rr + k) % NCH;
      for (int c = 0; c < NCH; c++) begin
        a = bus.replace_ack_sync[c*NACK +: NACK];
        case (ph[c])
          P_IDLE: if (bus.l1_replace_req[c]) begin
            if (bus.miss[c]) begin ph[c] = P_ACK; tcnt[c] = 0; e_rreq[c] = 1; end
            else e_upd[c] = 1;
          end
          P_ACK: begin
            if (|a) ph[c] = P_QUEUE;
`ifdef L2C_ACK_TIMEOUT_EN
            else if (tcnt[c] == TO_LIMIT) begin ph[c] = P_QUEUE; terr[c] = 1; end
            else tcnt[c]++;
`endif
          end
          P_QUEUE: if (c == g) begin
            own = c;
            ph[c] = bus.dirty[c] ? P_WBACK : bus.wb_read_tag_hit[c] ? P_STALL : P_FILL;
          end
          P_WBACK: if (bus.mem_dirty_done) ph[c] = bus.wb_read_tag_hit[c] ? P_STALL : P_FILL;
          P_STALL: if (!bus.wb_read_tag_hit[c]) ph[c] = P_FILL;
          P_FILL: if (bus.mem_replace_done) begin
            ph[c] = P_IDLE; e_upd[c] = 1; own = -1; rr = (c + 1) % NCH;
          end
          default: ;
        endcase
      end
    end
    e_dreq = (own >= 0) && ph[own] == P_WBACK;
    e_rpl  = (own >= 0) && ph[own] == P_FILL;
    e_id   = (e_dreq || e_rpl) ? own : 0;
    for (int c = 0; c < NCH; c++) e_err[c] = terr[c];
  endtask

  task automatic check_all();
    chk("replace_req",     32'(bus.replace_req),     32'(e_rreq));
    chk("update_ena",      32'(bus.update_ena),      32'(e_upd));
    chk("mem_dirty_req",   32'(bus.mem_dirty_req),   32'(e_dreq));
    chk("mem_replace_req", 32'(bus.mem_replace_req), 32'(e_rpl));
    chk("mem_addr_sel",    32'(bus.mem_addr_sel),    32'(e_dreq));
    chk("mem_ch_id",       32'(bus.mem_ch_id),       e_id);
    chk("ack_timeout_err", 32'(bus.ack_timeout_err), 32'(e_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_rpl(input string tag);
    for (int n = 0; n < 40 && !bus.mem_replace_req; n++) tick();
    chk(tag, 32'(bus.mem_replace_req), 1);
  endtask

  task automatic wait_drq(input string tag);
    for (int n = 0; n < 40 && !bus.mem_dirty_req; n++) tick();
    chk(tag, 32'(bus.mem_dirty_req), 1);
  endtask

  task automatic clear_in();
    bus.l1_replace_req   = '0;
    bus.miss             = '0;
    bus.dirty            = '0;
    bus.wb_read_tag_hit  = '0;
    bus.replace_ack_sync = '0;
    bus.mem_dirty_done   = 1'b0;
    bus.mem_replace_done = 1'b0;
  endtask

  task automatic ack(input int c);
    bus.replace_ack_sync[c*NACK] = 1'b1;
    tick();
    bus.replace_ack_sync = '0;
  endtask

  int order [4];

  initial begin
    for (int c = 0; c < NCH; c++) begin ph[c] = P_IDLE; tcnt[c] = 0; terr[c] = 0; end
    clear_in();
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_outputs", {bus.replace_req, bus.update_ena, bus.mem_dirty_req,
                          bus.mem_replace_req, bus.mem_addr_sel}, 0);
    rst_n = 1'b1;
    tick();

    // hit on ch0
    bus.l1_replace_req[0] = 1'b1;
    tick();
    bus.l1_replace_req[0] = 1'b0;
    chk("hit_upd_pulse", 32'(bus.update_ena[0]), 1);
    chk("hit_no_mem", 32'(bus.mem_replace_req | bus.mem_dirty_req), 0);
    tick();
    chk("hit_upd_single", 32'(bus.update_ena[0]), 0);

    // clean miss on ch1
    bus.l1_replace_req[1] = 1'b1; bus.miss[1] = 1'b1;
    tick();
    clear_in();
    chk("clean_rreq", 32'(bus.replace_req[1]), 1);
    tick();
    ack(1);
    wait_rpl("clean_rpl");
    chk("clean_id", 32'(bus.mem_ch_id), 1);
    bus.mem_replace_done = 1'b1;
    tick();
    bus.mem_replace_done = 1'b0;
    chk("clean_upd", 32'(bus.update_ena[1]), 1);
    chk("clean_rpl_drop", 32'(bus.mem_replace_req), 0);

    // dirty miss with write-buffer stall on ch0
    bus.l1_replace_req[0] = 1'b1; bus.miss[0] = 1'b1;
    bus.dirty[0] = 1'b1; bus.wb_read_tag_hit[0] = 1'b1;
    tick();
    bus.l1_replace_req[0] = 1'b0;
    ack(0);
    wait_drq("dirty_drq");
    chk("dirty_sel", 32'(bus.mem_addr_sel), 1);
    bus.mem_dirty_done = 1'b1;
    tick();
    bus.mem_dirty_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_rpl_low", 32'(bus.mem_replace_req), 0);
      chk("stall_sel_low", 32'(bus.mem_addr_sel), 0);
    end
    bus.wb_read_tag_hit[0] = 1'b0;
    tick();
    chk("stall_rpl_rise", 32'(bus.mem_replace_req), 1);
    bus.mem_replace_done = 1'b1;
    tick();
    clear_in();

    // contention with pointer at 0; ch1 ack arrives mid-sequence
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.l1_replace_req = 4'b1111; bus.miss = 4'b1111;
    tick();
    clear_in();
    bus.replace_ack_sync = 8'b0101_0001;
    tick();
    bus.replace_ack_sync = '0;
    for (int s = 0; s < 4; s++) begin
      wait_rpl("arb_wait");
      order[s] = int'(bus.mem_ch_id);
      if (s == 1) ack(1);
      bus.mem_replace_done = 1'b1;
      tick();
      bus.mem_replace_done = 1'b0;
    end
    chk("arb_order0", order[0], 0);
    chk("arb_order1", order[1], 2);
    chk("arb_order2", order[2], 3);
    chk("arb_order3", order[3], 1);

    // reset in the middle of a writeback
    bus.l1_replace_req[3] = 1'b1; bus.miss[3] = 1'b1; bus.dirty[3] = 1'b1;
    tick();
    bus.l1_replace_req[3] = 1'b0;
    ack(3);
    wait_drq("rst_drq");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_out", {bus.mem_dirty_req, bus.mem_replace_req, bus.mem_addr_sel,
                        bus.replace_req, bus.update_ena}, 0);
    bus.mem_dirty_done = 1'b1;
    tick(); tick();
    chk("rst_done_ignored", 32'(bus.mem_replace_req | bus.mem_dirty_req), 0);
    clear_in();

    // ack timeout (or indefinite wait when the feature is absent) on ch2
    bus.l1_replace_req[2] = 1'b1; bus.miss[2] = 1'b1;
    tick();
    clear_in();
`ifdef L2C_ACK_TIMEOUT_EN
    for (int n = 0; n < 40 && !bus.ack_timeout_err[2]; n++) tick();
    chk("to_err_set", 32'(bus.ack_timeout_err[2]), 1);
`else
    for (int n = 0; n < 20; n++) tick();
    chk("to_err_absent", 32'(bus.ack_timeout_err), 0);
    chk("to_no_mem", 32'(bus.mem_replace_req), 0);
    ack(2);
`endif
    wait_rpl("to_rpl");
    bus.mem_replace_done = 1'b1;
    tick();
    bus.mem_replace_done = 1'b0;
    tick();
`ifdef L2C_ACK_TIMEOUT_EN
    chk("to_err_sticky", 32'(bus.ack_timeout_err[2]), 1);
`endif

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < NCH; c++) begin
        bus.l1_replace_req[c]  = ($urandom_range(0, 9) < 3);
        bus.miss[c]            = $urandom_range(0, 1) == 1;
        bus.dirty[c]           = $urandom_range(0, 1) == 1;
        bus.wb_read_tag_hit[c] = ($urandom_range(0, 3) == 0);
      end
      for (int b = 0; b < NCH*NACK; b++) bus.replace_ack_sync[b] = ($urandom_range(0, 9) < 2);
      bus.mem_dirty_done   = ($urandom_range(0, 9) < 3);
      bus.mem_replace_done = ($urandom_range(0, 9) < 3);
      tick();
    end
    clear_in();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
